mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the RV32I pipeline, sitting between the EX/MEM pipeline register and the write-back stage. It consumes the EX/MEM outputs, runs load/store transactions on a req/ack data-memory port, and aligns, sign-extends and byte-enables the data. It stalls the upstream pipeline while a transaction is outstanding and holds the MEM/WB pipeline register internally.

## Interface
Parameters:
- TIMEOUT_CYC, 15: wait cycles without ack before the access is aborted.
- ADDR_W, 32: address width.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in  in  1  control from EX/MEM.
- funct3_in  in  3  load/store width code.
- ula_res_in  in  32  ALU result; the address for loads and stores.
- val_B_in  in  32  store data.
- rd_in  in  5  destination register.
- stall  out  1  combinational; high freezes EX/MEM (drives its enable low) and the earlier stages.
- dmem_req  out  1  request.
- dmem_we  out  1  write.
- dmem_addr  out  ADDR_W  word address, bits [1:0] = 0.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  completion.
- dmem_rdata  in  32  read data, valid with ack.
- reg_wr_out, mux_reg_wr_out  out  1  to WB.
- ula_res_out, mem_data_out  out  32  to WB.
- rd_out  out  5  to WB.
- bus_err_out  out  1  one-cycle pulse on an aborted access.

## Operation
- access = mem_rd_in | mem_wr_in. When both are high, the access is a write and the read is ignored.
- FSM states:
  - IDLE: an access asserts dmem_req combinationally in the same cycle. With dmem_ack in that cycle, the access completes with no stall. Otherwise stall=1 and the next state is WAIT.
  - WAIT: dmem_req is held and the inputs are stable because upstream is frozen. A counter increments each cycle.
    - On dmem_ack: stall=0 and the next state is IDLE.
    - When the counter reaches TIMEOUT_CYC without ack: stall=0, dmem_req=0, and the next state is ABORT.
  - ABORT: a single cycle in which bus_err_out is registered high, the result is dropped, and the next state is IDLE.
- stall = access & ~dmem_ack while in IDLE or WAIT (before timeout).
- dmem_ack outside an active request is ignored.
- Loads: the lane is chosen by addr[1:0].
  - LB (000) and LH (001) sign-extend; LBU (100) and LHU (101) zero-extend; LW (010) passes the word.
  - The result goes to mem_data_out.
- Stores: SB replicates the byte to all 4 lanes, with be = 0001 shifted by addr[1:0].
  - SH replicates the half-word, with be = 0011 or 1100 selected by addr[1].
  - SW uses be = 1111.
  - dmem_be = 0000 on reads.
- MEM/WB register, updated each edge:
  - When not stalled: captures the control, ula_res, load data and rd.
  - While stalled or in ABORT: captures a bubble (reg_wr_out=0, mux_reg_wr_out=0; data fields hold).
- Non-memory instructions (access=0) pass through in one cycle with no dmem_req.

## Timing
- Reset (async): state=IDLE, counter=0, dmem_req=0, stall=0. All MEM/WB outputs and bus_err_out are 0.
- Latency is input to MEM/WB outputs in 1 cycle, plus N stall cycles for N wait cycles of ack.
- Reset during WAIT drops dmem_req immediately, and no write-back occurs.
- Abort after TIMEOUT_CYC+1 stalled cycles: bus_err_out is high for exactly 1 cycle, and reg_wr_out=0 for that instruction.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, issue no request and no stall.
  - The instruction is bubbled (reg_wr_out=0), and a misalign_out port (out, 1) pulses high for one cycle alongside it.
- Not defined: the misalign_out port is absent. Half accesses ignore addr[0]; word accesses ignore addr[1:0].

## Structure
- Shared package rv32i_pkg holds:
  - the funct3 load/store encodings;
  - the mem FSM state enum (IDLE, WAIT, ABORT);
  - byte-enable constants.
- Sub-module load_align (combinational): takes rdata, addr[1:0] and funct3, and produces the extended load data. It is instantiated once.

## Test plan
- LW at 0x100, ack same cycle, rdata=0xDEADBEEF → no stall; next cycle mem_data_out=0xDEADBEEF, reg_wr_out=1.
- LB at 0x103, rdata=0x80FF_FFFF → mem_data_out=0xFFFFFF80. Same with LBU → 0x00000080.
- SB at 0x102 with val_B=0x12345678 → dmem_wdata=0x78787878, dmem_be=0100, dmem_we=1.
- SW with ack after 3 cycles → stall high for exactly 3 cycles, reg_wr_out=0 during the stall, then normal completion.
- No ack → stall for 16 cycles, then bus_err_out pulses once, dmem_req falls, and reg_wr_out stays 0.
- rst asserted in WAIT → dmem_req=0 and all outputs 0 immediately. With MEM_MISALIGN_TRAP_EN, LW at 0x101 → misalign_out=1 and no dmem_req.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the memory stage: load/store funct3 codes,
// memory-access FSM states, byte-enable constants and store-lane helpers.
// Ports: none (package).
package rv32i_pkg;

   // funct3 encodings for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;   // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;   // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;   // LW / SW
   localparam logic [2:0] F3_BU = 3'b100;   // LBU
   localparam logic [2:0] F3_HU = 3'b101;   // LHU

   // Memory-access FSM
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ABORT = 2'd2
   } mem_state_e;

   // Byte-enable constants
   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B0   = 4'b0001;
   localparam logic [3:0] BE_HLO  = 4'b0011;
   localparam logic [3:0] BE_HHI  = 4'b1100;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Store byte enables; half stores pick the lane pair with addr[1] only.
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B:    return BE_B0 << a;
         F3_H:    return a[1] ? BE_HHI : BE_HLO;
         default: return BE_WORD;
      endcase
   endfunction

   // Store data replicated across lanes so the byte enables alone select it.
   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] v);
      case (f3)
         F3_B:    return {4{v[7:0]}};
         F3_H:    return {2{v[15:0]}};
         default: return v;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: selects the addressed byte/half-word lane of the read
// word and sign- or zero-extends it according to funct3 (purely combinational).
// Ports: rdata_i read word, addr_i addr[1:0], funct3_i width code, data_o result.
module load_align
   import rv32i_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  addr_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[7:0];
      case (addr_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
         default: byte_sel = rdata_i[7:0];
      endcase
      // addr[0] is deliberately ignored for halves
      half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      data_o = rdata_i;
      case (funct3_i)
         F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data_o = {24'd0, byte_sel};
         F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data_o = {16'd0, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: runs loads/stores on a req/ack data port, aligns
// load data, stalls upstream while an access is outstanding, and holds MEM/WB.
// Ports: EX/MEM controls + ula_res/val_B/rd in; stall out; dmem_* req/ack port;
// MEM/WB outputs (reg_wr/mux_reg_wr/ula_res/mem_data/rd) and bus_err_out pulse.
// Option MEM_MISALIGN_TRAP_EN adds misalign_out and suppresses misaligned accesses.
module mem_stage
   import rv32i_pkg::*;
#(
   parameter int TIMEOUT_CYC = 15,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_rd_in,
   input  logic              mem_wr_in,
   input  logic              reg_wr_in,
   input  logic              mux_reg_wr_in,
   input  logic [2:0]        funct3_in,
   input  logic [31:0]       ula_res_in,
   input  logic [31:0]       val_B_in,
   input  logic [4:0]        rd_in,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata,
   output logic              reg_wr_out,
   output logic              mux_reg_wr_out,
   output logic [31:0]       ula_res_out,
   output logic [31:0]       mem_data_out,
   output logic [4:0]        rd_out,
   output logic              bus_err_out
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic              misalign_out
`endif
);

   localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        access, misaligned, go;
   logic        req_c, stall_c, timeout_c, bubble_c;
   logic [31:0] load_data;

   logic        reg_wr_q, mux_reg_wr_q, bus_err_q, misalign_q;
   logic [31:0] ula_res_q, mem_data_q;
   logic [4:0]  rd_q;

   assign access = mem_rd_in | mem_wr_in;

`ifdef MEM_MISALIGN_TRAP_EN
   // Half codes share funct3[1:0]=01, word uses 10
   assign misaligned = access & (((funct3_in[1:0] == 2'b01) & ula_res_in[0]) |
                                 ((funct3_in[1:0] == 2'b10) & (|ula_res_in[1:0])));
`else
   assign misaligned = 1'b0;
`endif

   assign go = access & ~misaligned;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_c     = 1'b0;
      stall_c   = 1'b0;
      timeout_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (go) begin
               req_c = 1'b1;
               if (!dmem_ack) begin
                  stall_c = 1'b1;
                  state_d = WAIT;
                  cnt_d   = '0;
               end
            end
         end
         WAIT: begin
            if (!go) begin
               state_d = IDLE;
            end else if (dmem_ack) begin
               // ack wins over a simultaneous timeout
               req_c   = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
               // release upstream with the request dropped; result discarded
               timeout_c = 1'b1;
               state_d   = ABORT;
            end else begin
               req_c   = 1'b1;
               stall_c = 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ABORT: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset must silence the combinational outputs immediately
   assign stall    = stall_c & ~rst;
   assign dmem_req = req_c & ~rst;
   assign dmem_we  = dmem_req & mem_wr_in;

   assign dmem_addr  = {ula_res_in[ADDR_W-1:2], 2'b00};
   assign dmem_wdata = store_wdata(funct3_in, val_B_in);
   assign dmem_be    = mem_wr_in ? store_be(funct3_in, ula_res_in[1:0]) : BE_NONE;

   load_align u_load_align (
      .rdata_i  (dmem_rdata),
      .addr_i   (ula_res_in[1:0]),
      .funct3_i (funct3_in),
      .data_o   (load_data)
   );

   assign bubble_c = stall_c | timeout_c | (state_q == ABORT) | misaligned;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         reg_wr_q     <= 1'b0;
         mux_reg_wr_q <= 1'b0;
         ula_res_q    <= '0;
         mem_data_q   <= '0;
         rd_q         <= '0;
         bus_err_q    <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bus_err_q  <= timeout_c;
         misalign_q <= misaligned & (state_q == IDLE);
         if (bubble_c) begin
            reg_wr_q     <= 1'b0;
            mux_reg_wr_q <= 1'b0;
         end else begin
            reg_wr_q     <= reg_wr_in;
            mux_reg_wr_q <= mux_reg_wr_in;
            ula_res_q    <= ula_res_in;
            mem_data_q   <= load_data;
            rd_q         <= rd_in;
         end
      end
   end

   assign reg_wr_out     = reg_wr_q;
   assign mux_reg_wr_out = mux_reg_wr_q;
   assign ula_res_out    = ula_res_q;
   assign mem_data_out   = mem_data_q;
   assign rd_out         = rd_q;
   assign bus_err_out    = bus_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
   assign misalign_out   = misalign_q;
`else
   // keep the flop tied off cleanly when the trap is compiled out
   logic unused_misalign;
   assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
   localparam int TMO   = 15;
   localparam int NOACK = 99;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_rd_in, mem_wr_in, reg_wr_in, mux_reg_wr_in;
   logic [2:0]  funct3_in;
   logic [31:0] ula_res_in, val_B_in;
   logic [4:0]  rd_in;
   logic        stall, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        reg_wr_out, mux_reg_wr_out;
   logic [31:0] ula_res_out, mem_data_out;
   logic [4:0]  rd_out;
   logic        bus_err_out;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_out;
`endif

   always #5 clk = ~clk;

   mem_stage #(.TIMEOUT_CYC(TMO), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .reg_wr_in(reg_wr_in),
      .mux_reg_wr_in(mux_reg_wr_in), .funct3_in(funct3_in), .ula_res_in(ula_res_in),
      .val_B_in(val_B_in), .rd_in(rd_in), .stall(stall),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
      .dmem_rdata(dmem_rdata), .reg_wr_out(reg_wr_out), .mux_reg_wr_out(mux_reg_wr_out),
      .ula_res_out(ula_res_out), .mem_data_out(mem_data_out), .rd_out(rd_out),
      .bus_err_out(bus_err_out)
`ifdef MEM_MISALIGN_TRAP_EN
      , .misalign_out(misalign_out)
`endif
   );

   typedef struct {
      logic        mux;
      logic [4:0]  rd;
      logic [31:0] ula;
      logic        is_ld;
      logic [31:0] data;
   } wb_exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } mem_exp_t;

   wb_exp_t  wb_q[$];
   mem_exp_t mem_q[$];
   int checks = 0, errors = 0;
   int err_seen = 0, err_exp = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model: shift the word down to the addressed lane, then extend.
   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> (8 * int'(a)));
      h = 16'(w >> (16 * int'(a[1])));
      case (f3)
         3'd0: return 32'($signed(b));
         3'd4: return 32'(b);
         3'd1: return 32'($signed(h));
         3'd5: return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] v);
      case (f3)
         3'd0: return 32'(v[7:0]) * 32'h0101_0101;
         3'd1: return 32'(v[15:0]) * 32'h0001_0001;
         default: return v;
      endcase
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'd0: return 4'(1 << int'(a));
         3'd1: return (a >= 2'd2) ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Monitor: pops expectations whenever the DUT presents a write-back or request.
   always @(negedge clk) begin : mon
      wb_exp_t  e;
      mem_exp_t m;
      if (!rst) begin
         if (reg_wr_out) begin
            if (wb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL wb_unexpected rd=%0d ula=%h", rd_out, ula_res_out);
            end else begin
               e = wb_q.pop_front();
               chk("wb_rd", 32'(rd_out), 32'(e.rd));
               chk("wb_ula", ula_res_out, e.ula);
               chk("wb_mux", 32'(mux_reg_wr_out), 32'(e.mux));
               if (e.is_ld) chk("wb_load", mem_data_out, e.data);
            end
         end
         if (dmem_req) begin
            if (mem_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL mem_unexpected addr=%h", dmem_addr);
            end else begin
               m = mem_q[0];
               chk("mem_we", 32'(dmem_we), 32'(m.we));
               chk("mem_addr", dmem_addr, m.addr);
               chk("mem_be", 32'(dmem_be), 32'(m.be));
               if (m.we) chk("mem_wdata", dmem_wdata, m.wdata);
               if (dmem_ack) void'(mem_q.pop_front());
            end
         end
         if (bus_err_out) err_seen++;
      end
   end

   task automatic set_nop();
      mem_rd_in = 0; mem_wr_in = 0; reg_wr_in = 0; mux_reg_wr_in = 0;
      funct3_in = 0; ula_res_in = 0; val_B_in = 0; rd_in = 0; dmem_ack = 0;
   endtask

   // Drive one instruction as EX/MEM would, holding it while stall is expected.
   // dly = cycle index of ack (NOACK for none).
   task automatic issue(input logic rd_, input logic wr_, input logic rw, input logic mx,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] v,
                        input logic [4:0] rdn, input int dly, input logic [31:0] rdat);
      logic acc, exp_stall, aborted;
      int   k;
      bit   done;
      acc = rd_ | wr_;
      aborted = 0;
      done = 0;
      k = 0;
      mem_rd_in = rd_; mem_wr_in = wr_; reg_wr_in = rw; mux_reg_wr_in = mx;
      funct3_in = f3; ula_res_in = a; val_B_in = v; rd_in = rdn;
      if (acc)
         mem_q.push_back('{we: wr_, addr: {a[31:2], 2'b00}, wdata: ref_wdata(f3, v),
                           be: wr_ ? ref_be(f3, a[1:0]) : 4'b0000});
      while (!done) begin
         dmem_ack   = acc && (k == dly);
         dmem_rdata = (acc && k == dly) ? rdat : $urandom;
         @(negedge clk);
         exp_stall = acc && (k < dly) && (k <= TMO);
         chk("stall", 32'(stall), 32'(exp_stall));
         if (acc && k > TMO) chk("req_timeout", 32'(dmem_req), 32'(0));
         else chk("req", 32'(dmem_req), 32'(acc));
         if (!exp_stall) begin
            done = 1;
            if (acc && k > TMO) aborted = 1;
            else if (rw) wb_q.push_back('{mux: mx, rd: rdn, ula: a, is_ld: rd_ & ~wr_,
                                          data: ref_load(f3, a[1:0], rdat)});
         end
         @(posedge clk); #1;
         k++;
      end
      dmem_ack = 0;
      if (aborted) begin
         void'(mem_q.pop_front());
         err_exp++;
         set_nop();
         @(negedge clk);
         chk("abort_bus_err", 32'(bus_err_out), 32'(1));
         chk("abort_reg_wr", 32'(reg_wr_out), 32'(0));
         chk("abort_req", 32'(dmem_req), 32'(0));
         @(posedge clk); #1;
         @(negedge clk);
         chk("abort_pulse_end", 32'(bus_err_out), 32'(0));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0]  f3;
      logic        r, w;
      int          dly, sel;
      rst = 1;
      set_nop();
      dmem_rdata = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", 32'(stall), 0);
      chk("rst_req", 32'(dmem_req), 0);
      chk("rst_reg_wr", 32'(reg_wr_out), 0);
      chk("rst_bus_err", 32'(bus_err_out), 0);
      chk("rst_mem_data", mem_data_out, 0);
      rst = 0;
      @(posedge clk); #1;

      // Directed cases
      issue(1, 0, 1, 0, 3'd2, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF);
      chk("lw_direct", mem_data_out, 32'hDEADBEEF);
      chk("lw_direct_regwr", 32'(reg_wr_out), 1);
      issue(1, 0, 1, 1, 3'd0, 32'h103, 32'h0, 5'd6, 0, 32'h80FF_FFFF);
      chk("lb_direct", mem_data_out, 32'hFFFF_FF80);
      issue(1, 0, 1, 0, 3'd4, 32'h103, 32'h0, 5'd7, 0, 32'h80FF_FFFF);
      chk("lbu_direct", mem_data_out, 32'h0000_0080);
      issue(0, 1, 0, 0, 3'd0, 32'h102, 32'h1234_5678, 5'd0, 0, 32'h0);
      issue(0, 1, 0, 0, 3'd2, 32'h200, 32'hCAFE_F00D, 5'd0, 3, 32'h0);
      issue(1, 0, 1, 0, 3'd1, 32'h302, 32'h0, 5'd9, 2, 32'h8001_7FFF);
      chk("lh_wait_direct", mem_data_out, 32'hFFFF_8001);
      issue(0, 0, 1, 1, 3'd0, 32'h5555_AAAA, 32'h0, 5'd10, 0, 32'h0);
      issue(1, 0, 1, 0, 3'd2, 32'h400, 32'h0, 5'd11, NOACK, 32'h0);
      issue(1, 1, 0, 0, 3'd1, 32'h501, 32'hABCD_1234, 5'd12, 1, 32'h0);

      // Reset while waiting for ack
      mem_rd_in = 1; mem_wr_in = 0; reg_wr_in = 1; mux_reg_wr_in = 0;
      funct3_in = 3'd2; ula_res_in = 32'h600; val_B_in = 0; rd_in = 5'd13; dmem_ack = 0;
      mem_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0, be: 4'b0000});
      repeat (3) @(posedge clk);
      @(negedge clk); #2;
      rst = 1;
      #1;
      chk("rst_wait_req", 32'(dmem_req), 0);
      chk("rst_wait_stall", 32'(stall), 0);
      chk("rst_wait_regwr", 32'(reg_wr_out), 0);
      chk("rst_wait_ula", ula_res_out, 0);
      void'(mem_q.pop_front());
      set_nop();
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      // Randomized traffic
      for (int i = 0; i < 250; i++) begin
         sel = $urandom_range(0, 9);
         r = 0; w = 0;
         if (sel < 4) r = 1;
         else if (sel < 7) w = 1;
         else if (sel == 7) begin r = 1; w = 1; end
         if (w) f3 = 3'($urandom_range(0, 2));
         else begin
            sel = $urandom_range(0, 4);
            f3 = (sel == 3) ? 3'd4 : (sel == 4) ? 3'd5 : 3'(sel);
         end
         sel = $urandom_range(0, 99);
         dly = (sel < 60) ? 0 : (sel < 97) ? $urandom_range(1, 4) : NOACK;
         issue(r, w, ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom),
               f3, $urandom, $urandom, 5'($urandom), dly, $urandom);
      end

      set_nop();
      repeat (3) @(posedge clk);
      #1;
      chk("wb_queue_drained", 32'(wb_q.size()), 0);
      chk("mem_queue_drained", 32'(mem_q.size()), 0);
      chk("bus_err_pulses", 32'(err_seen), 32'(err_exp));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
